// File: rtl/alu4_issue_ctrl.sv
// Issue/writeback control for the 4-bit ALU: 4x4 register file, two-state
// issue FSM, external load port, and a wrapping retired-instruction counter.
module alu4_issue_ctrl #(
  parameter int NREG  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [8:0]       instr,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [3:0]       ld_data,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [3:0]       alu_out,
  output logic [3:0]       result,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  input  logic [1:0]       dbg_addr,
  output logic [3:0]       dbg_data
);

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  instr_t     ins;
  state_t     state, state_nxt;
  logic [3:0] rf [NREG];
  logic [1:0] rd_q;
  logic       accept, wb;

  assign ins = instr_t'(instr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wb        = 1'b0;
    case (state)
      IDLE: if (instr_valid) begin
        accept    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        wb        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign instr_ready = (state == IDLE);

  // ALU writeback has priority over an external load to the same entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb && rd_q == 2'(i))                rf[i] <= alu_out;
        else if (ld_en && ld_addr == 2'(i))     rf[i] <= ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rd_q       <= '0;
      result     <= '0;
      done       <= 1'b0;
      retired    <= '0;
    end else begin
      done <= wb;
      if (accept) begin
        alu_a      <= rf[ins.rs1];
        alu_b      <= rf[ins.rs2];
        alu_opcode <= ins.op;
        rd_q       <= ins.rd;
      end
      if (wb) begin
        result  <= alu_out;
        retired <= retired + 1'b1;
      end
    end
  end

  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu4_issue_ctrl.sv
// Directed bench for alu4_issue_ctrl: the bench supplies the ALU, keeps a
// register-file model, and scoreboards writebacks queued at accept time.
module tb_alu4_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [3:0] alu_a, alu_b, alu_out, result, dbg_data;
  logic [2:0] alu_opcode;
  logic       done;
  logic [7:0] retired;
  logic [1:0] dbg_addr;

  always #5 clk = ~clk;

  alu4_issue_ctrl #(.NREG(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .result(result), .done(done), .retired(retired),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic [2:0] op);
    case (op)
      3'b001:  alu = a + b;
      3'b010:  alu = a - b;
      3'b011:  alu = a & b;
      3'b100:  alu = a | b;
      3'b101:  alu = ~a;
      3'b110:  alu = ~b;
      default: alu = 4'h0;
    endcase
  endfunction

  assign alu_out = alu(alu_a, alu_b, alu_opcode);

  typedef struct {
    logic [1:0] rd;
    logic [3:0] val;
  } wb_t;

  wb_t        q[$];
  logic [3:0] m_rf [4];
  logic [7:0] m_ret;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic [1:0] a);
    dbg_addr = a;
    #1;
    chk(tag, 32'(dbg_data), 32'(m_rf[a]));
  endtask

  task automatic do_ld(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_rf[a] = d;
    chk_rf("ld_rf", a);
  endtask

  // Waits for ready, queues the expected writeback, checks the issued operands.
  task automatic accept(input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2);
    int n = 0;
    logic [3:0] ea, eb;
    instr = {op, rd, rs1, rs2};
    instr_valid = 1'b1;
    while (!instr_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 8), 32'd1);
    ea = m_rf[rs1];
    eb = m_rf[rs2];
    q.push_back('{rd, alu(ea, eb, op)});
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_opcode", 32'(alu_opcode), 32'(op));
    chk("ready_exec", 32'(instr_ready), 32'd0);
    chk("done_exec", 32'(done), 32'd0);
  endtask

  // Writeback edge, optionally with a concurrent external load.
  task automatic wb(input logic ld, input logic [1:0] la, input logic [3:0] ldd);
    wb_t e;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    @(posedge clk); #1;
    ld_en = 1'b0;
    chk("done_wb", 32'(done), 32'd1);
    chk("ready_wb", 32'(instr_ready), 32'd1);
    if (q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'(q.size()));
    end else begin
      e = q.pop_front();
      chk("result", 32'(result), 32'(e.val));
      m_rf[e.rd] = e.val;
      if (ld && la != e.rd) m_rf[la] = ldd;
      m_ret = m_ret + 8'd1;
      chk("retired", 32'(retired), 32'(m_ret));
      chk_rf("wb_rf", e.rd);
      if (ld) chk_rf("ld_side_rf", la);
    end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_ret = 8'd0;
    #12;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while EXEC: the in-flight ADD must vanish
    do_ld(2'd0, 4'd5);
    accept(3'b001, 2'd1, 2'd0, 2'd0);
    rst = 1'b1;
    #2;
    q.delete();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_ret = 8'd0;
    chk("rstx_ready", 32'(instr_ready), 32'd1);
    chk("rstx_retired", 32'(retired), 32'd0);
    chk_rf("rstx_r1", 2'd1);
    chk_rf("rstx_r0", 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstx_nodone", 32'(done), 32'd0);
      chk("rstx_ready_after", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
    end
    chk("rstx_retired_after", 32'(retired), 32'd0);

    // Basic ADD r2 = r0 + r1
    do_ld(2'd0, 4'd3);
    do_ld(2'd1, 4'd1);
    accept(3'b001, 2'd2, 2'd0, 2'd1);
    wb(1'b0, 2'd0, 4'd0);
    chk("add_r2", 32'(result), 32'd4);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    // SUB wrap and NOT-A
    accept(3'b010, 2'd3, 2'd1, 2'd0);
    wb(1'b0, 2'd0, 4'd0);
    chk("sub_wrap", 32'(result), 32'hE);
    accept(3'b101, 2'd3, 2'd0, 2'd1);
    wb(1'b0, 2'd0, 4'd0);
    chk("not_a", 32'(result), 32'hC);

    // Back-to-back with valid held through EXEC; second reads new r2
    accept(3'b001, 2'd2, 2'd0, 2'd1);
    instr = {3'b100, 2'd3, 2'd2, 2'd0};
    instr_valid = 1'b1;
    wb(1'b0, 2'd0, 4'd0);
    accept(3'b100, 2'd3, 2'd2, 2'd0);
    chk("b2b_alu_a", 32'(alu_a), 32'd4);
    wb(1'b0, 2'd0, 4'd0);
    chk("b2b_r3", 32'(result), 32'd7);

    // Load colliding with writeback: same address loses, other address lands
    accept(3'b001, 2'd2, 2'd0, 2'd1);
    wb(1'b1, 2'd2, 4'd9);
    chk("coll_same_r2", 32'(dbg_data), 32'd4);
    accept(3'b001, 2'd2, 2'd0, 2'd1);
    wb(1'b1, 2'd0, 4'd9);
    chk("coll_diff_r0", 32'(dbg_data), 32'd9);
    chk_rf("coll_diff_r2", 2'd2);

    // Random traffic until the retired counter wraps to zero
    for (int k = 0; k < 300 && m_ret != 8'd0; k++) begin
      if ($urandom_range(0, 3) == 0)
        do_ld(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      accept(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      wb(1'b0, 2'd0, 4'd0);
    end
    chk("ret_wrap", 32'(retired), 32'd0);

    // Opcode 111 still issues: writes 0 and pulses done
    do_ld(2'd1, 4'd5);
    accept(3'b111, 2'd1, 2'd0, 2'd0);
    wb(1'b0, 2'd0, 4'd0);
    chk("op111_r1", 32'(dbg_data), 32'd0);
    chk("op111_retired", 32'(retired), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
